cyclic_decoder_syndrome: RTL
============================

CYCLIC_DECODER_SYNDROME -- requirements
Module: cyclic_decoder_syndrome

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 enable  input  1  bit strobe; when 1, one serial code bit is sampled from in on the rising edge.
REQ-004 in  input  1  serial received (15,11) codeword bit, highest degree first: c14..c4 are data d10..d0, c3..c0 are parity.
REQ-005 out  output  1  serial decoded data bit, d10 first.
REQ-006 out_valid  output  1  out carries a data bit.
REQ-007 err  output  1  syndrome of the frame being output was nonzero.

Function
REQ-008 The block SHALL decode the systematic (15,11) cyclic code with g(x)=x^4+x+1.
REQ-009 Frame position counter pos SHALL run 0..14, advance only on enable=1 edges, wrap 14->0, and hold when enable=0.
REQ-010 The 4-bit syndrome register s SHALL update on each enable edge as s <= (s*x + in) mod g(x); it SHALL clear at the pos=14 edge after the final value is used.
REQ-011 A 15-bit input buffer SHALL shift in each enabled bit; on the pos=14 edge the full codeword (including that cycle's in) and the final syndrome SHALL be transferred to the output stage.
REQ-012 The syndrome-to-position map SHALL be x^j mod g (s3..s0): j0 0001, j1 0010, j2 0100, j3 1000, j4 0011, j5 0110, j6 1100, j7 1011, j8 0101, j9 1010, j10 0111, j11 1110, j12 1111, j13 1101, j14 1001.
REQ-013 A nonzero syndrome SHALL flip bit j of the codeword before output; for j in 0..3 the data SHALL pass unchanged.
REQ-014 A double error SHALL be miscorrected silently; no uncorrectable flag exists.
REQ-015 The pos=14 edge SHALL load the 11-bit output shifter, drive out<=d10, set out_valid<=1, and set err<=(syndrome!=0).
REQ-016 Enable edges at pos 0..9 of the next frame SHALL shift out d9..d0 in order.
REQ-017 The pos=10 edge SHALL drive out<=0, out_valid<=0 and err<=0.
REQ-018 out_valid SHALL therefore be high for exactly 11 enabled cycles per frame.
REQ-019 Decoded output of frame k SHALL overlap the input of frame k+1, so back-to-back frames run with no gap.
REQ-020 When enable=0, out, out_valid, err and all state SHALL hold, stretching the output.
REQ-021 Outputs SHALL be registered, with no combinational path from in to out.

Reset
REQ-022 reset=1 SHALL set pos=0, s=0, the buffers to 0, out=0, out_valid=0 and err=0.
REQ-023 reset SHALL take priority over enable.
REQ-024 Reset mid-frame SHALL discard the partial frame and any pending output; the next enabled bit is pos 0.
REQ-025 No output SHALL occur until a complete frame has been received after reset.

Configuration
REQ-026 Macro CYCLIC_DECODER_CORRECT_EN defined: correction per REQ-013.
REQ-027 Macro CYCLIC_DECODER_CORRECT_EN undefined: no bit is flipped, data bits pass exactly as received, and err is still computed and reported identically (detect-only).

Verification
REQ-028 All-zero codeword 0x0000, continuous enable: out=0 for 11 cycles, out_valid high 11 cycles starting at the pos=14 edge, err=0.
REQ-029 Codeword for d=0x001 (0x0013), then the same with c14 flipped (0x4013): both frames output 00000000001, err=0 then err=1 (syndrome 1001).
REQ-030 0x0017 (parity bit c2 flipped): output 00000000001, err=1; with the macro undefined, 0x4013 outputs 10000000001, err=1.
REQ-031 0x0013 with enable deasserted 3 cycles at pos 5 and 3 cycles during output: identical data sequence, with outputs held during the gaps.
REQ-032 Reset at pos 7 of frame 1, then frame 0x4013: no out_valid before the new frame completes, then output 00000000001 with err=1.

Source files
------------

// File: rtl/cyclic_decoder_syndrome_if.sv
// Serial bit-stream interface for the (15,11) cyclic decoder.
//   enable    : bit strobe, one code bit is taken from `in` when high
//   in        : received code bit, highest degree first
//   out       : decoded data bit, d10 first
//   out_valid : `out` carries a data bit
//   err       : syndrome of the frame currently being output was nonzero
// master drives enable/in, slave drives out/out_valid/err.
interface cyclic_decoder_syndrome_if;
    logic enable;
    logic in;
    logic out;
    logic out_valid;
    logic err;

    modport master (
        output enable,
        output in,
        input  out,
        input  out_valid,
        input  err
    );

    modport slave (
        input  enable,
        input  in,
        output out,
        output out_valid,
        output err
    );
endinterface

// File: rtl/cyclic_decoder_syndrome.sv
// Syndrome decoder for the systematic (15,11) cyclic code, g(x) = x^4 + x + 1.
// A frame of 15 enabled bits is accumulated into a syndrome; on its last bit
// the (optionally corrected) 11 data bits are handed to an output shifter that
// streams d10..d0 while the next frame is being received.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : cyclic_decoder_syndrome_if.slave (enable, in -> out, out_valid, err)
// Configuration:
//   CYCLIC_DECODER_CORRECT_EN defined   -> single-bit errors in data bits are flipped
//   CYCLIC_DECODER_CORRECT_EN undefined -> detect only, data passes as received
module cyclic_decoder_syndrome (
    input  logic                        clk,
    input  logic                        reset,
    cyclic_decoder_syndrome_if.slave    bus
);
    localparam int unsigned N        = 15;
    localparam int unsigned K        = 11;
    localparam int unsigned R        = N - K;
    localparam int unsigned POS_W    = 4;
    localparam logic [R-1:0]     G_LOW    = R'(4'b0011);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N - 1);
    localparam logic [POS_W-1:0] POS_DATA = POS_W'(K);
    localparam logic [POS_W-1:0] POS_SHFT = POS_W'(K - 1);

    logic [POS_W-1:0] pos_q,   pos_d;
    logic [R-1:0]     syn_q,   syn_d;
    logic [K-1:0]     data_q,  data_d;
    logic [K-2:0]     shreg_q, shreg_d;
    logic             out_q,   out_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;

    logic [R-1:0]     syn_next;
    logic [K-1:0]     data_full;
    logic [K-1:0]     data_fix;

`ifdef CYCLIC_DECODER_CORRECT_EN
    // Syndrome -> flip mask over data bits c14..c4 (mask bit i = c(i+4)).
    // Syndromes of parity positions c3..c0 leave the data untouched.
    function automatic logic [K-1:0] data_err_mask(input logic [R-1:0] syn);
        logic [K-1:0] m;
        m = '0;
        case (syn)
            4'b0011: m = K'(11'h001);
            4'b0110: m = K'(11'h002);
            4'b1100: m = K'(11'h004);
            4'b1011: m = K'(11'h008);
            4'b0101: m = K'(11'h010);
            4'b1010: m = K'(11'h020);
            4'b0111: m = K'(11'h040);
            4'b1110: m = K'(11'h080);
            4'b1111: m = K'(11'h100);
            4'b1101: m = K'(11'h200);
            4'b1001: m = K'(11'h400);
            default: m = '0;
        endcase
        return m;
    endfunction
`endif

    // Syndrome step: s*x + in, reducing x^4 to x + 1.
    always_comb begin
        syn_next = {syn_q[R-2:0], bus.in} ^ (syn_q[R-1] ? G_LOW : '0);
    end

    // Parity bits only feed the syndrome, so only the data bits are buffered.
    // On the final bit of a frame data_q already holds c14..c4.
    always_comb begin
        data_full = data_q;
`ifdef CYCLIC_DECODER_CORRECT_EN
        data_fix  = data_full ^ data_err_mask(syn_next);
`else
        data_fix  = data_full;
`endif
    end

    // Next-state and output logic.
    always_comb begin
        pos_d   = pos_q;
        syn_d   = syn_q;
        data_d  = data_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (bus.enable) begin
            if (pos_q == POS_LAST) begin
                // Frame complete: hand off to the output stage, restart syndrome.
                pos_d   = '0;
                syn_d   = '0;
                shreg_d = data_fix[K-2:0];
                out_d   = data_fix[K-1];
                valid_d = 1'b1;
                err_d   = |syn_next;
            end else begin
                pos_d = pos_q + POS_W'(1);
                syn_d = syn_next;
                if (pos_q < POS_DATA) begin
                    data_d = {data_q[K-2:0], bus.in};
                end
                // Output phase of the previous frame overlaps this frame's input.
                if (pos_q < POS_SHFT) begin
                    out_d   = shreg_q[K-2];
                    shreg_d = {shreg_q[K-3:0], 1'b0};
                end else if (pos_q == POS_SHFT) begin
                    out_d   = 1'b0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            syn_q   <= '0;
            data_q  <= '0;
            shreg_q <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            syn_q   <= syn_d;
            data_q  <= data_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.err       = err_q;

endmodule
